// File: rtl/ctrl_pkt_gen.sv
// ctrl_pkt_gen: turns single register-write commands into CHDR control packets
// on a 64-bit AXI-stream and tracks the response stream coming back.
//
// Ports:
//   clk, reset_n (async active-low), clear (sync soft clear)
//   cmd_*   : command input (valid/ready), address/data/optional timestamp
//   ctrl_*  : outgoing packet stream (header, [time], payload with tlast)
//   resp_*  : response stream from the downstream processor (always ready)
//   seqnum_err  : one-cycle pulse on a response sequence-number mismatch
//   outstanding : issued-minus-answered packet count
//
// Optional feature macro: CTRL_PKT_GEN_SEQ_CHECK_EN
//   defined   -> credit gating on MAX_OUTSTANDING plus response seqnum checking
//   undefined -> responses drained and ignored, seqnum_err/outstanding held 0
module ctrl_pkt_gen #(
  parameter logic [31:0] SID             = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        cmd_tvalid,
  output logic        cmd_tready,
  input  logic [15:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic        cmd_timed,
  input  logic [63:0] cmd_time,
  output logic [63:0] ctrl_tdata,
  output logic        ctrl_tlast,
  output logic        ctrl_tvalid,
  input  logic        ctrl_tready,
  input  logic [63:0] resp_tdata,
  input  logic        resp_tlast,
  input  logic        resp_tvalid,
  output logic        resp_tready,
  output logic        seqnum_err,
  output logic [7:0]  outstanding
);

  localparam int unsigned SEQ_W  = 12;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned BUS_W  = 64;
  localparam logic [15:0] LEN_UNTIMED = 16'd4;
  localparam logic [15:0] LEN_TIMED   = 16'd6;

  typedef enum logic [1:0] {IDLE, HEAD, TIME, DATA} state_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic        timed;
    logic [63:0] ts;
  } cmd_t;

  state_e             state_q, state_d;
  cmd_t               cmd_q, cmd_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [BUS_W-1:0]   ctrl_tdata_q, ctrl_tdata_d;
  logic               ctrl_tlast_q, ctrl_tlast_d;
  logic               ctrl_tvalid_q, ctrl_tvalid_d;
  logic               cmd_tready_q, cmd_tready_d;
  logic               resp_tready_q;
  logic               seqnum_err_q, seqnum_err_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic               data_acc;

  // Packet FSM: command capture, beat sequencing, seqnum advance.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    seq_d    = seq_q;
    data_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_tvalid && cmd_tready_q) begin
          cmd_d   = '{addr: cmd_addr, data: cmd_data, timed: cmd_timed, ts: cmd_time};
          state_d = HEAD;
        end
      end
      HEAD: begin
        if (ctrl_tready) state_d = cmd_q.timed ? TIME : DATA;
      end
      TIME: begin
        if (ctrl_tready) state_d = DATA;
      end
      DATA: begin
        if (ctrl_tready) begin
          data_acc = 1'b1;
          seq_d    = seq_q + SEQ_W'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d  = IDLE;
      seq_d    = '0;
      data_acc = 1'b0;
    end
  end

`ifdef CTRL_PKT_GEN_SEQ_CHECK_EN
  logic [SEQ_W-1:0] exp_q, exp_d;
  logic             resp_first_q, resp_first_d;
  logic             resp_dec;
  logic             unused_resp;

  assign unused_resp = ^{resp_tdata[63:60], resp_tdata[47:0]};

  // Response tracking: only the first beat of each packet carries a seqnum.
  always_comb begin
    exp_d        = exp_q;
    resp_first_d = resp_first_q;
    seqnum_err_d = 1'b0;
    resp_dec     = 1'b0;
    if (resp_tvalid) begin
      resp_first_d = resp_tlast;
      if (resp_first_q) begin
        if (outstanding_q == '0) begin
          // Nothing issued to answer: flag it, leave counters alone.
          seqnum_err_d = 1'b1;
        end else begin
          resp_dec     = 1'b1;
          seqnum_err_d = (resp_tdata[59:48] != exp_q);
          exp_d        = exp_q + SEQ_W'(1);
        end
      end
    end
    outstanding_d = outstanding_q + CNT_W'(data_acc) - CNT_W'(resp_dec);
    if (clear) begin
      exp_d         = '0;
      resp_first_d  = 1'b1;
      seqnum_err_d  = 1'b0;
      outstanding_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q        <= '0;
      resp_first_q <= 1'b1;
    end else begin
      exp_q        <= exp_d;
      resp_first_q <= resp_first_d;
    end
  end
`else
  logic unused_resp;

  assign unused_resp = ^{resp_tdata, resp_tlast, resp_tvalid, data_acc,
                         CNT_W'(MAX_OUTSTANDING)};

  always_comb begin
    seqnum_err_d  = 1'b0;
    outstanding_d = '0;
  end
`endif

  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    ctrl_tvalid_d = (state_d != IDLE);
    ctrl_tlast_d  = (state_d == DATA);
    ctrl_tdata_d  = '0;
    case (state_d)
      // Header: {type=2'b10, has_time, eob=0, seqnum, length, SID}
      HEAD:    ctrl_tdata_d = {1'b1, 1'b0, cmd_d.timed, 1'b0, seq_d,
                               (cmd_d.timed ? LEN_TIMED : LEN_UNTIMED), SID};
      TIME:    ctrl_tdata_d = cmd_d.ts;
      DATA:    ctrl_tdata_d = {16'h0000, cmd_d.addr, cmd_d.data};
      default: ctrl_tdata_d = '0;
    endcase
`ifdef CTRL_PKT_GEN_SEQ_CHECK_EN
    cmd_tready_d = (state_d == IDLE) && (outstanding_d < CNT_W'(MAX_OUTSTANDING));
`else
    cmd_tready_d = (state_d == IDLE);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      seq_q         <= '0;
      ctrl_tdata_q  <= '0;
      ctrl_tlast_q  <= 1'b0;
      ctrl_tvalid_q <= 1'b0;
      cmd_tready_q  <= 1'b1;
      resp_tready_q <= 1'b1;
      seqnum_err_q  <= 1'b0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      seq_q         <= seq_d;
      ctrl_tdata_q  <= ctrl_tdata_d;
      ctrl_tlast_q  <= ctrl_tlast_d;
      ctrl_tvalid_q <= ctrl_tvalid_d;
      cmd_tready_q  <= cmd_tready_d;
      resp_tready_q <= 1'b1;
      seqnum_err_q  <= seqnum_err_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign cmd_tready  = cmd_tready_q;
  assign ctrl_tdata  = ctrl_tdata_q;
  assign ctrl_tlast  = ctrl_tlast_q;
  assign ctrl_tvalid = ctrl_tvalid_q;
  assign resp_tready = resp_tready_q;
  assign seqnum_err  = seqnum_err_q;
  assign outstanding = outstanding_q;

endmodule

// File: tb/tb_ctrl_pkt_gen.sv
`timescale 1ns/1ps
module tb_ctrl_pkt_gen;

`ifdef CTRL_PKT_GEN_SEQ_CHECK_EN
  localparam bit SEQ_CHK = 1'b1;
`else
  localparam bit SEQ_CHK = 1'b0;
`endif
  localparam logic [31:0] TB_SID = 32'hDEAD_BEEF;

  logic        clk, reset_n, clear;
  logic        cmd_tvalid, cmd_tready;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_timed;
  logic [63:0] cmd_time;
  logic [63:0] ctrl_tdata;
  logic        ctrl_tlast, ctrl_tvalid, ctrl_tready;
  logic [63:0] resp_tdata;
  logic        resp_tlast, resp_tvalid, resp_tready;
  logic        seqnum_err;
  logic [7:0]  outstanding;

  ctrl_pkt_gen #(.SID(TB_SID), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_timed(cmd_timed), .cmd_time(cmd_time),
    .ctrl_tdata(ctrl_tdata), .ctrl_tlast(ctrl_tlast),
    .ctrl_tvalid(ctrl_tvalid), .ctrl_tready(ctrl_tready),
    .resp_tdata(resp_tdata), .resp_tlast(resp_tlast),
    .resp_tvalid(resp_tvalid), .resp_tready(resp_tready),
    .seqnum_err(seqnum_err), .outstanding(outstanding)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Capture of one packet produced by run_cmd
  logic [63:0] cap_data [8];
  logic        cap_last [8];
  int          cap_n, cap_lat, cap_stab_err, cap_rdy_err;
  logic        cap_tmo, cap_first_valid;

  // Observations made by send_resp
  logic        obs_err0, obs_rdy0, obs_err_rest;
  logic [7:0]  obs_out0;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic        timed;
    logic [63:0] ts;
    bit          bp;
    int          nbeats;
    logic [63:0] hdr;
    logic [63:0] pay;
  } vec_t;
  vec_t vecs [6];

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Issue one command and collect its beats; all driving/sampling on negedges.
  task automatic run_cmd(input logic [15:0] a, input logic [31:0] d, input logic t,
                         input logic [63:0] ts, input bit bp);
    int guard;
    int cyc;
    logic [63:0] held;
    bit stalled;
    bit done;
    cap_n = 0; cap_lat = 0; cap_stab_err = 0; cap_rdy_err = 0;
    cap_tmo = 1'b0; cap_first_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cap_data[k] = '0;
      cap_last[k] = 1'b0;
    end
    cmd_addr = a; cmd_data = d; cmd_timed = t; cmd_time = ts; cmd_tvalid = 1'b1;
    guard = 0;
    while (!cmd_tready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_tready) begin
      cap_tmo = 1'b1;
      cmd_tvalid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_tvalid = 1'b0;
    cmd_addr = 16'($urandom);
    cmd_data = $urandom;
    cmd_timed = ~t;
    cmd_time = {$urandom, $urandom};
    cap_first_valid = ctrl_tvalid;
    cyc = 1; stalled = 1'b0; held = '0; done = 1'b0;
    while (!done && cyc < 200) begin
      ctrl_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cmd_tready) cap_rdy_err++;
      if (stalled && (!ctrl_tvalid || ctrl_tdata !== held)) cap_stab_err++;
      if (ctrl_tvalid && ctrl_tready) begin
        if (cap_n < 8) begin
          cap_data[cap_n] = ctrl_tdata;
          cap_last[cap_n] = ctrl_tlast;
        end
        cap_n++;
        stalled = 1'b0;
        if (ctrl_tlast) begin
          done = 1'b1;
          cap_lat = cyc;
        end
      end else begin
        stalled = ctrl_tvalid;
        held = ctrl_tdata;
      end
      @(negedge clk);
      cyc++;
    end
    if (!done) cap_tmo = 1'b1;
    ctrl_tready = 1'b1;
  endtask

  // Send one response packet; seqnum only in the first beat's [59:48].
  task automatic send_resp(input logic [11:0] sq, input int nbeats);
    obs_err_rest = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      resp_tvalid = 1'b1;
      resp_tlast  = (b == nbeats - 1);
      resp_tdata  = (b == 0) ? {4'h0, sq, 48'h0} : {4'hF, ~sq, 48'hFFFF_FFFF_FFFF};
      @(negedge clk);
      if (b == 0) begin
        obs_err0 = seqnum_err;
        obs_out0 = outstanding;
        obs_rdy0 = cmd_tready;
      end else begin
        obs_err_rest = obs_err_rest | seqnum_err;
      end
    end
    resp_tvalid = 1'b0;
    resp_tlast  = 1'b0;
    resp_tdata  = '0;
    @(negedge clk);
    obs_err_rest = obs_err_rest | seqnum_err;
  endtask

  int          wrap_tmo;
  logic [63:0] hdr_fff;
  bit          rdy_ok;

  initial begin
    reset_n = 1'b1; clear = 1'b0; cmd_tvalid = 1'b0; cmd_addr = '0; cmd_data = '0;
    cmd_timed = 1'b0; cmd_time = '0; ctrl_tready = 1'b1;
    resp_tdata = '0; resp_tlast = 1'b0; resp_tvalid = 1'b0;

    //           addr      data           timed ts                     bp  n  header                  payload
    vecs[0] = '{16'h000B, 32'hF00D_1234, 1'b0, 64'h0,                1'b0, 2, 64'h8000_0004_DEAD_BEEF, 64'h0000_000B_F00D_1234};
    vecs[1] = '{16'h0010, 32'h1111_2222, 1'b1, 64'h20,               1'b0, 3, 64'hA001_0006_DEAD_BEEF, 64'h0000_0010_1111_2222};
    vecs[2] = '{16'hFFFF, 32'hFFFF_FFFF, 1'b0, 64'h5555_5555_5555_5555, 1'b1, 2, 64'h8002_0004_DEAD_BEEF, 64'h0000_FFFF_FFFF_FFFF};
    vecs[3] = '{16'h1234, 32'hCAFE_BABE, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 3, 64'hA003_0006_DEAD_BEEF, 64'h0000_1234_CAFE_BABE};
    vecs[4] = '{16'h0000, 32'h0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3, 64'hA004_0006_DEAD_BEEF, 64'h0000_0000_0000_0000};
    vecs[5] = '{16'h8001, 32'h8000_0001, 1'b0, 64'h0,                1'b0, 2, 64'h8005_0004_DEAD_BEEF, 64'h0000_8001_8000_0001};

    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl_tvalid", 64'(ctrl_tvalid), 64'd0);
    chk("rst_ctrl_tlast", 64'(ctrl_tlast), 64'd0);
    chk("rst_ctrl_tdata", ctrl_tdata, 64'd0);
    chk("rst_seqnum_err", 64'(seqnum_err), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_resp_tready", 64'(resp_tready), 64'd1);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_tready", 64'(cmd_tready), 64'd1);

    for (int i = 0; i < 6; i++) begin
      run_cmd(vecs[i].addr, vecs[i].data, vecs[i].timed, vecs[i].ts, vecs[i].bp);
      chk($sformatf("v%0d_timeout", i), 64'(cap_tmo), 64'd0);
      chk($sformatf("v%0d_hdr_at_n1", i), 64'(cap_first_valid), 64'd1);
      chk($sformatf("v%0d_nbeats", i), 64'(cap_n), 64'(vecs[i].nbeats));
      chk($sformatf("v%0d_hdr", i), cap_data[0], vecs[i].hdr);
      if (vecs[i].timed) chk($sformatf("v%0d_time", i), cap_data[1], vecs[i].ts);
      chk($sformatf("v%0d_payload", i), cap_data[vecs[i].nbeats - 1], vecs[i].pay);
      for (int b = 0; b < vecs[i].nbeats; b++)
        chk($sformatf("v%0d_tlast_b%0d", i, b), 64'(cap_last[b]), 64'(b == vecs[i].nbeats - 1));
      chk($sformatf("v%0d_stable", i), 64'(cap_stab_err), 64'd0);
      chk($sformatf("v%0d_cmd_rdy_low", i), 64'(cap_rdy_err), 64'd0);
      if (!vecs[i].bp) chk($sformatf("v%0d_latency", i), 64'(cap_lat), 64'(vecs[i].nbeats));
      chk($sformatf("v%0d_cmd_rdy_after", i), 64'(cmd_tready), 64'd1);
      chk($sformatf("v%0d_outstanding", i), 64'(outstanding), SEQ_CHK ? 64'd1 : 64'd0);
      send_resp(12'(i), 2);
      chk($sformatf("v%0d_resp_err", i), 64'(obs_err0), 64'd0);
      chk($sformatf("v%0d_resp_out", i), 64'(obs_out0), 64'd0);
      chk($sformatf("v%0d_resp_err_rest", i), 64'(obs_err_rest), 64'd0);
    end

    // Clear while a timed packet sits in its TIME beat
    cmd_addr = 16'h0ABC; cmd_data = 32'h1357_9BDF; cmd_timed = 1'b1;
    cmd_time = 64'h7777; cmd_tvalid = 1'b1;
    rdy_ok = 1'b0;
    for (int g = 0; g < 50 && !rdy_ok; g++) begin
      if (cmd_tready) rdy_ok = 1'b1;
      else @(negedge clk);
    end
    chk("clr_cmd_accept", 64'(rdy_ok), 64'd1);
    @(negedge clk);
    cmd_tvalid = 1'b0;
    chk("clr_head_valid", 64'(ctrl_tvalid), 64'd1);
    chk("clr_head_seq", 64'(ctrl_tdata[59:48]), 64'd6);
    @(negedge clk);
    chk("clr_in_time", ctrl_tdata, 64'h7777);
    do_clear();
    chk("clr_tvalid_drop", 64'(ctrl_tvalid), 64'd0);
    chk("clr_cmd_tready", 64'(cmd_tready), 64'd1);
    chk("clr_outstanding", 64'(outstanding), 64'd0);
    run_cmd(16'h0001, 32'h0000_0002, 1'b0, 64'h0, 1'b0);
    chk("clr_next_hdr", cap_data[0], 64'h8000_0004_DEAD_BEEF);
    send_resp(12'h000, 1);
    chk("clr_resp_err", 64'(obs_err0), 64'd0);

`ifdef CTRL_PKT_GEN_SEQ_CHECK_EN
    // Credit gating with MAX_OUTSTANDING = 2 and responses withheld
    do_clear();
    run_cmd(16'h0100, 32'h1, 1'b0, 64'h0, 1'b0);
    run_cmd(16'h0101, 32'h2, 1'b0, 64'h0, 1'b0);
    chk("cr_out_two", 64'(outstanding), 64'd2);
    cmd_addr = 16'h0102; cmd_data = 32'h3; cmd_timed = 1'b0; cmd_tvalid = 1'b1;
    repeat (4) @(negedge clk);
    chk("cr_stall_rdy", 64'(cmd_tready), 64'd0);
    chk("cr_stall_tvalid", 64'(ctrl_tvalid), 64'd0);
    chk("cr_stall_out", 64'(outstanding), 64'd2);
    cmd_tvalid = 1'b0;
    send_resp(12'h000, 1);
    chk("cr_rel_out", 64'(obs_out0), 64'd1);
    chk("cr_rel_rdy", 64'(obs_rdy0), 64'd1);
    chk("cr_rel_err", 64'(obs_err0), 64'd0);
    run_cmd(16'h0102, 32'h3, 1'b0, 64'h0, 1'b0);
    chk("cr_third_tmo", 64'(cap_tmo), 64'd0);
    chk("cr_third_hdr", cap_data[0], 64'h8002_0004_DEAD_BEEF);
    send_resp(12'h001, 1);
    send_resp(12'h002, 1);
    chk("cr_drained", 64'(outstanding), 64'd0);

    // Mismatched seqnum, then a response with nothing outstanding
    do_clear();
    run_cmd(16'h0200, 32'h4, 1'b0, 64'h0, 1'b0);
    send_resp(12'h005, 1);
    chk("mm_err_pulse", 64'(obs_err0), 64'd1);
    chk("mm_out_dec", 64'(obs_out0), 64'd0);
    chk("mm_err_one_cycle", 64'(obs_err_rest), 64'd0);
    send_resp(12'h001, 1);
    chk("sp_err_pulse", 64'(obs_err0), 64'd1);
    chk("sp_out_zero", 64'(obs_out0), 64'd0);
`endif

    // Seqnum wrap: the 4097th header after clear carries seqnum 0
    do_clear();
    wrap_tmo = 0;
    hdr_fff = '0;
    for (int i = 0; i < 4096; i++) begin
      run_cmd(16'(i), 32'(i), 1'b0, 64'h0, 1'b0);
      if (cap_tmo) wrap_tmo++;
      if (i == 4095) hdr_fff = cap_data[0];
`ifdef CTRL_PKT_GEN_SEQ_CHECK_EN
      send_resp(12'(i), 1);
`endif
    end
    chk("wrap_timeouts", 64'(wrap_tmo), 64'd0);
    chk("wrap_seq_fff", 64'(hdr_fff[59:48]), 64'hFFF);
    run_cmd(16'h4097, 32'h0000_4097, 1'b0, 64'h0, 1'b0);
    chk("wrap_seq_000", cap_data[0], 64'h8000_0004_DEAD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
